// File: rtl/astar_pkg.sv
// Shared A* pipeline definitions: FSM encoding, direction codes, neighbour offset
// tables and the grid size defaults that the closed-list search stage also uses.
package astar_pkg;

  localparam int GRID_W_DEF = 20;
  localparam int GRID_H_DEF = 20;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_GEN  = 3'd1,
    ST_WALL = 3'd2,
    ST_WAIT = 3'd3,
    ST_EMIT = 3'd4,
    ST_NEXT = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  localparam logic [2:0] DIR_N  = 3'd0;
  localparam logic [2:0] DIR_E  = 3'd1;
  localparam logic [2:0] DIR_S  = 3'd2;
  localparam logic [2:0] DIR_W  = 3'd3;
  localparam logic [2:0] DIR_NE = 3'd4;
  localparam logic [2:0] DIR_SE = 3'd5;
  localparam logic [2:0] DIR_SW = 3'd6;
  localparam logic [2:0] DIR_NW = 3'd7;

  // Two-bit two's-complement offsets (-1, 0, +1) indexed by direction code.
  localparam logic [1:0] DX_TAB [8] = '{2'b00, 2'b01, 2'b00, 2'b11, 2'b01, 2'b01, 2'b11, 2'b11};
  localparam logic [1:0] DY_TAB [8] = '{2'b11, 2'b00, 2'b01, 2'b00, 2'b11, 2'b01, 2'b01, 2'b11};

endpackage

// File: rtl/astar_nb_offset.sv
// Combinational neighbour coordinate: current node plus direction offset, with a
// flag telling whether the result lies inside the grid.
module astar_nb_offset
  import astar_pkg::*;
#(
  parameter int COORD_W = 8,
  parameter int GRID_W  = GRID_W_DEF,
  parameter int GRID_H  = GRID_H_DEF
) (
  input  logic [COORD_W-1:0] cur_x,
  input  logic [COORD_W-1:0] cur_y,
  input  logic [2:0]         dir,
  output logic [COORD_W-1:0] cand_x,
  output logic [COORD_W-1:0] cand_y,
  output logic               in_grid
);

  localparam logic [COORD_W:0] GW = (COORD_W+1)'(GRID_W);
  localparam logic [COORD_W:0] GH = (COORD_W+1)'(GRID_H);

  logic [1:0]       dx, dy;
  logic [COORD_W:0] dx_ext, dy_ext, sx, sy;

  assign dx     = DX_TAB[dir];
  assign dy     = DY_TAB[dir];
  assign dx_ext = {{(COORD_W-1){dx[1]}}, dx};
  assign dy_ext = {{(COORD_W-1){dy[1]}}, dy};

  // One extra bit so that 0-1 shows up as negative instead of wrapping to the top.
  assign sx = {1'b0, cur_x} + dx_ext;
  assign sy = {1'b0, cur_y} + dy_ext;

  assign cand_x  = sx[COORD_W-1:0];
  assign cand_y  = sy[COORD_W-1:0];
  assign in_grid = !sx[COORD_W] && !sy[COORD_W] && (sx < GW) && (sy < GH);

endmodule

// File: rtl/astar_neighbor_gen.sv
// Expansion stage: walks the neighbours of the popped node, filters off-grid and wall
// cells, queries the closed list and forwards unvisited cells to the open-list insert.
module astar_neighbor_gen
  import astar_pkg::*;
#(
  parameter int GRID_W  = GRID_W_DEF,
  parameter int GRID_H  = GRID_H_DEF,
  parameter int COORD_W = 8,
  parameter int DIAG    = 0
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               cur_valid,
  output logic               cur_ready,
  input  logic [COORD_W-1:0] cur_x,
  input  logic [COORD_W-1:0] cur_y,
  output logic               wall_req,
  output logic [COORD_W-1:0] wall_x,
  output logic [COORD_W-1:0] wall_y,
  input  logic               wall_hit,
  output logic               chk_start,
  output logic [COORD_W-1:0] chk_x,
  output logic [COORD_W-1:0] chk_y,
  input  logic               chk_done,
  input  logic               chk_found,
  output logic               nb_valid,
  input  logic               nb_ready,
  output logic [COORD_W-1:0] nb_x,
  output logic [COORD_W-1:0] nb_y,
  output logic               exp_done,
  output logic [3:0]         nb_count
);

  localparam logic [2:0] LAST_DIR = (DIAG != 0) ? DIR_NW : DIR_W;

  state_t             state;
  logic [COORD_W-1:0] node_x, node_y;
  logic [2:0]         dir;
  logic [3:0]         count;
  logic [COORD_W-1:0] cand_x, cand_y;
  logic               in_grid;

  astar_nb_offset #(
    .COORD_W (COORD_W),
    .GRID_W  (GRID_W),
    .GRID_H  (GRID_H)
  ) u_offset (
    .cur_x   (node_x),
    .cur_y   (node_y),
    .dir     (dir),
    .cand_x  (cand_x),
    .cand_y  (cand_y),
    .in_grid (in_grid)
  );

  // The wall map answers one cycle after the request, so the strobe is decoded in GEN
  // itself and the answer lands in WALL.
  assign wall_req = (state == ST_GEN) && in_grid;
  assign wall_x   = wall_req ? cand_x : '0;
  assign wall_y   = wall_req ? cand_y : '0;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= ST_IDLE;
      cur_ready <= 1'b1;
      node_x    <= '0;
      node_y    <= '0;
      dir       <= '0;
      count     <= '0;
      chk_start <= 1'b0;
      chk_x     <= '0;
      chk_y     <= '0;
      nb_valid  <= 1'b0;
      nb_x      <= '0;
      nb_y      <= '0;
      exp_done  <= 1'b0;
      nb_count  <= '0;
    end else begin
      chk_start <= 1'b0;
      exp_done  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cur_valid) begin
            node_x    <= cur_x;
            node_y    <= cur_y;
            dir       <= '0;
            count     <= '0;
            cur_ready <= 1'b0;
            state     <= ST_GEN;
          end
        end
        ST_GEN: state <= in_grid ? ST_WALL : ST_NEXT;
        ST_WALL: begin
          if (wall_hit) begin
            state <= ST_NEXT;
          end else begin
            chk_start <= 1'b1;
            chk_x     <= cand_x;
            chk_y     <= cand_y;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (chk_done) begin
            if (chk_found) begin
              state <= ST_NEXT;
            end else begin
              nb_valid <= 1'b1;
              nb_x     <= chk_x;
              nb_y     <= chk_y;
              state    <= ST_EMIT;
            end
          end
        end
        ST_EMIT: begin
          if (nb_ready) begin
            nb_valid <= 1'b0;
            if (count < 4'd8) count <= count + 4'd1;
            state <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          if (dir == LAST_DIR) begin
            exp_done <= 1'b1;
            nb_count <= count;
            state    <= ST_DONE;
          end else begin
            dir   <= dir + 3'd1;
            state <= ST_GEN;
          end
        end
        ST_DONE: begin
          cur_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_astar_neighbor_gen.sv
// Bench for astar_neighbor_gen: a 4-connected and an 8-connected instance, with
// behavioural wall-map and closed-list responders and a scoreboard of expected neighbours.
module tb_astar_neighbor_gen;

  localparam int GW = 20;
  localparam int GH = 20;
  localparam int SEARCH_LAT = 2;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       cur_valid [2];
  logic       cur_ready [2];
  logic [7:0] cur_x [2];
  logic [7:0] cur_y [2];
  logic       wall_req [2];
  logic [7:0] wall_x [2];
  logic [7:0] wall_y [2];
  logic       wall_hit [2];
  logic       chk_start [2];
  logic [7:0] chk_x [2];
  logic [7:0] chk_y [2];
  logic       chk_done [2];
  logic       chk_found [2];
  logic       nb_valid [2];
  logic       nb_ready [2];
  logic [7:0] nb_x [2];
  logic [7:0] nb_y [2];
  logic       exp_done [2];
  logic [3:0] nb_count [2];

  always #5 Clk = ~Clk;

  astar_neighbor_gen #(.GRID_W(GW), .GRID_H(GH), .COORD_W(8), .DIAG(0)) u_dut4 (
    .Clk(Clk), .Reset(Reset),
    .cur_valid(cur_valid[0]), .cur_ready(cur_ready[0]), .cur_x(cur_x[0]), .cur_y(cur_y[0]),
    .wall_req(wall_req[0]), .wall_x(wall_x[0]), .wall_y(wall_y[0]), .wall_hit(wall_hit[0]),
    .chk_start(chk_start[0]), .chk_x(chk_x[0]), .chk_y(chk_y[0]),
    .chk_done(chk_done[0]), .chk_found(chk_found[0]),
    .nb_valid(nb_valid[0]), .nb_ready(nb_ready[0]), .nb_x(nb_x[0]), .nb_y(nb_y[0]),
    .exp_done(exp_done[0]), .nb_count(nb_count[0])
  );

  astar_neighbor_gen #(.GRID_W(GW), .GRID_H(GH), .COORD_W(8), .DIAG(1)) u_dut8 (
    .Clk(Clk), .Reset(Reset),
    .cur_valid(cur_valid[1]), .cur_ready(cur_ready[1]), .cur_x(cur_x[1]), .cur_y(cur_y[1]),
    .wall_req(wall_req[1]), .wall_x(wall_x[1]), .wall_y(wall_y[1]), .wall_hit(wall_hit[1]),
    .chk_start(chk_start[1]), .chk_x(chk_x[1]), .chk_y(chk_y[1]),
    .chk_done(chk_done[1]), .chk_found(chk_found[1]),
    .nb_valid(nb_valid[1]), .nb_ready(nb_ready[1]), .nb_x(nb_x[1]), .nb_y(nb_y[1]),
    .exp_done(exp_done[1]), .nb_count(nb_count[1])
  );

  int errors = 0;
  int checks = 0;

  bit wall_map   [GW][GH];
  bit closed_map [GW][GH];

  logic [15:0] exp_q [2][$];
  int  exp_chk   [2];
  int  chk_cnt   [2];
  int  exp_cnt   [2];
  bit  done_seen [2];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Wall map and closed-list search models; not reset so a search in flight survives a DUT reset.
  bit         pend [2];
  int         cnt  [2];
  logic [7:0] lx [2];
  logic [7:0] ly [2];

  always @(posedge Clk) begin
    for (int i = 0; i < 2; i++) begin
      wall_hit[i]  <= wall_req[i] && wall_x[i] < GW && wall_y[i] < GH && wall_map[wall_x[i]][wall_y[i]];
      chk_done[i]  <= 1'b0;
      chk_found[i] <= 1'b0;
      if (pend[i]) begin
        if (cnt[i] == 0) begin
          chk_done[i]  <= 1'b1;
          chk_found[i] <= closed_map[lx[i]][ly[i]];
          pend[i]      <= 1'b0;
        end else begin
          cnt[i] <= cnt[i] - 1;
        end
      end
      if (chk_start[i]) begin
        pend[i] <= 1'b1;
        cnt[i]  <= SEARCH_LAT;
        lx[i]   <= chk_x[i];
        ly[i]   <= chk_y[i];
      end
    end
  end

  always @(negedge Clk) begin
    if (!Reset) begin
      for (int i = 0; i < 2; i++) begin
        if (chk_start[i]) begin
          chk_cnt[i]++;
          check("chk_in_grid", int'(chk_x[i] < GW && chk_y[i] < GH), 1);
        end
        if (nb_valid[i] && nb_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            check("nb_unexpected", {nb_x[i], nb_y[i]}, 16'hFFFF);
          end else begin
            check("nb_xy", {nb_x[i], nb_y[i]}, exp_q[i].pop_front());
          end
        end
        if (exp_done[i]) begin
          check("nb_count", nb_count[i], exp_cnt[i]);
          check("nb_all_emitted", exp_q[i].size(), 0);
          check("search_count", chk_cnt[i], exp_chk[i]);
          done_seen[i] = 1'b1;
        end
      end
    end
  end

  task automatic model(input int i, input int cx, input int cy);
    int nx, ny, dx, dy;
    exp_q[i].delete();
    exp_chk[i] = 0;
    for (int d = 0; d < ((i == 1) ? 8 : 4); d++) begin
      case (d)
        0: begin dx =  0; dy = -1; end
        1: begin dx =  1; dy =  0; end
        2: begin dx =  0; dy =  1; end
        3: begin dx = -1; dy =  0; end
        4: begin dx =  1; dy = -1; end
        5: begin dx =  1; dy =  1; end
        6: begin dx = -1; dy =  1; end
        default: begin dx = -1; dy = -1; end
      endcase
      nx = cx + dx;
      ny = cy + dy;
      if (nx >= 0 && nx < GW && ny >= 0 && ny < GH && !wall_map[nx][ny]) begin
        exp_chk[i]++;
        if (!closed_map[nx][ny]) exp_q[i].push_back({nx[7:0], ny[7:0]});
      end
    end
  endtask

  task automatic start_node(input int i, input int cx, input int cy, input int cnt_exp);
    model(i, cx, cy);
    exp_cnt[i]   = cnt_exp;
    chk_cnt[i]   = 0;
    done_seen[i] = 1'b0;
    @(posedge Clk); #1;
    check("cur_ready_idle", cur_ready[i], 1);
    cur_valid[i] = 1'b1;
    cur_x[i]     = 8'(cx);
    cur_y[i]     = 8'(cy);
    @(posedge Clk); #1;
    cur_valid[i] = 1'b0;
    check("cur_ready_busy", cur_ready[i], 0);
  endtask

  task automatic wait_done(input int i);
    int n = 0;
    while (!done_seen[i] && n < 500) begin
      @(negedge Clk);
      n++;
    end
    #1;
    check("exp_done_seen", done_seen[i], 1);
  endtask

  task automatic clear_maps();
    for (int x = 0; x < GW; x++)
      for (int y = 0; y < GH; y++) begin
        wall_map[x][y]   = 1'b0;
        closed_map[x][y] = 1'b0;
      end
  endtask

  typedef struct {
    int inst;
    int cx, cy;
    int wx, wy;
    int clx, cly;
    int cnt;
  } vec_t;

  vec_t vecs [8];

  initial begin
    bit         bad;
    int         n;
    logic [7:0] x0, y0;

    vecs[0] = '{0,  5,  5, -1, -1, -1, -1, 4};
    vecs[1] = '{0,  0,  0, -1, -1, -1, -1, 2};
    vecs[2] = '{0, 19, 19, 18, 19, 19, 18, 0};
    vecs[3] = '{0, 19,  0, -1, -1, -1, -1, 2};
    vecs[4] = '{0, 10, 19, 10, 18, -1, -1, 2};
    vecs[5] = '{1,  5,  5, -1, -1, -1, -1, 8};
    vecs[6] = '{1,  0,  0, -1, -1, -1, -1, 3};
    vecs[7] = '{1, 19, 19, -1, -1, 18, 18, 2};

    Reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cur_valid[i] = 1'b0;
      cur_x[i]     = '0;
      cur_y[i]     = '0;
      nb_ready[i]  = 1'b1;
      exp_cnt[i]   = 0;
      exp_chk[i]   = 0;
      chk_cnt[i]   = 0;
      done_seen[i] = 1'b0;
    end
    clear_maps();
    repeat (2) @(posedge Clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_cur_ready", cur_ready[i], 1);
      check("rst_strobes", {wall_req[i], chk_start[i], nb_valid[i], exp_done[i]}, 0);
      check("rst_nb_count", nb_count[i], 0);
      check("rst_coords", wall_x[i] | wall_y[i] | chk_x[i] | chk_y[i] | nb_x[i] | nb_y[i], 0);
    end
    @(posedge Clk); #1;
    Reset = 1'b0;

    for (int v = 0; v < 8; v++) begin
      clear_maps();
      if (vecs[v].wx >= 0) wall_map[vecs[v].wx][vecs[v].wy] = 1'b1;
      if (vecs[v].clx >= 0) closed_map[vecs[v].clx][vecs[v].cly] = 1'b1;
      start_node(vecs[v].inst, vecs[v].cx, vecs[v].cy, vecs[v].cnt);
      wait_done(vecs[v].inst);
    end

    // Downstream stall: first neighbour must hold for 10 cycles, then move on the first ready.
    clear_maps();
    nb_ready[0] = 1'b0;
    start_node(0, 5, 5, 4);
    n = 0;
    while (!nb_valid[0] && n < 100) begin
      @(negedge Clk);
      n++;
    end
    check("bp_valid_seen", nb_valid[0], 1);
    x0  = nb_x[0];
    y0  = nb_y[0];
    bad = 1'b0;
    repeat (10) begin
      @(negedge Clk);
      if (!nb_valid[0] || nb_x[0] != x0 || nb_y[0] != y0) bad = 1'b1;
    end
    check("bp_stable", bad, 0);
    @(posedge Clk); #1;
    nb_ready[0] = 1'b1;
    @(negedge Clk);
    @(negedge Clk);
    check("bp_first_high_xfer", nb_valid[0], 0);
    wait_done(0);

    // Reset while a closed-list search is outstanding; its late chk_done must be ignored.
    start_node(0, 5, 5, 4);
    n = 0;
    while (!chk_start[0] && n < 100) begin
      @(negedge Clk);
      n++;
    end
    check("rst_wait_reached", chk_start[0], 1);
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(negedge Clk);
    check("midrst_cur_ready", cur_ready[0], 1);
    check("midrst_strobes", {wall_req[0], chk_start[0], nb_valid[0], exp_done[0]}, 0);
    exp_q[0].delete();
    @(posedge Clk); #1;
    Reset = 1'b0;
    bad = 1'b0;
    repeat (8) begin
      @(negedge Clk);
      if (!cur_ready[0] || nb_valid[0] || exp_done[0] || chk_start[0] || wall_req[0]) bad = 1'b1;
    end
    check("stale_done_ignored", bad, 0);
    check("stale_done_drained", int'(pend[0]), 0);

    // Node accepted normally after the mid-search reset.
    start_node(0, 5, 5, 4);
    wait_done(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
